// File: rtl/if_fetch_buf.sv
// if_fetch_buf: prefetching instruction fetch stage. Drives a synchronous
// instruction ROM, tracks the single in-flight request and buffers returned
// {pc, inst} pairs in a DEPTH-entry FIFO whose head is presented to ID.
// Ports: clk/rst (async active-high); rom_addr_o/rom_ce_o/rom_data_i to the
// ROM; stall_i from ID; redirect_i/redirect_pc_i for branch/jump; id_valid_o,
// id_pc_o, id_inst_o, count_o to ID; bubble_cnt_o diagnostic counter.
// Optional feature macro: IF_FETCH_BUF_BUBBLE_CNT_EN enables the bubble
// counter; when undefined bubble_cnt_o is tied to zero.
// Latency: ROM request to id_valid_o is 2 cycles (request edge, capture edge).
// Backpressure: a fetch is issued only when a FIFO slot is guaranteed for its
// response, so the ROM is throttled rather than responses dropped.
module if_fetch_buf #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [ADDR_W-1:0]          rom_addr_o,
  output logic                       rom_ce_o,
  input  logic [DATA_W-1:0]          rom_data_i,
  input  logic                       stall_i,
  input  logic                       redirect_i,
  input  logic [ADDR_W-1:0]          redirect_pc_i,
  output logic                       id_valid_o,
  output logic [ADDR_W-1:0]          id_pc_o,
  output logic [DATA_W-1:0]          id_inst_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [31:0]                bubble_cnt_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] pc;
  logic              started;
  logic              inflight;
  logic [ADDR_W-1:0] inflight_pc;
  logic [ADDR_W-1:0] mem_pc   [DEPTH];
  logic [DATA_W-1:0] mem_inst [DEPTH];
  logic [PW-1:0]     rptr;
  logic [PW-1:0]     wptr;
  logic [CW-1:0]     count;

  logic              pop;
  logic              push;
  logic              issue;
  logic [CW:0]       occ;

  always_comb begin
    id_valid_o = (count != '0);
    pop        = id_valid_o & ~stall_i & ~redirect_i;
    push       = inflight & ~redirect_i;
    // Occupancy after this cycle's pop, counting the response still in
    // flight: a new request is only safe if that leaves a free slot.
    occ        = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
    issue      = started & ~redirect_i & (occ < (CW+1)'(DEPTH));
  end

  assign rom_ce_o   = issue;
  assign rom_addr_o = pc;
  assign id_pc_o    = mem_pc[rptr];
  assign id_inst_o  = mem_inst[rptr];
  assign count_o    = count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      started     <= 1'b0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      rptr        <= '0;
      wptr        <= '0;
      count       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc[i]   <= '0;
        mem_inst[i] <= '0;
      end
    end else begin
      started <= 1'b1;
      if (redirect_i) begin
        // Redirect beats everything: drop buffered entries and the
        // in-flight response, restart at the new target next cycle.
        pc       <= redirect_pc_i;
        inflight <= 1'b0;
        rptr     <= '0;
        wptr     <= '0;
        count    <= '0;
      end else begin
        inflight <= issue;
        if (issue) begin
          pc          <= pc + ADDR_W'(4);
          inflight_pc <= pc;
        end
        if (push) begin
          mem_pc[wptr]   <= inflight_pc;
          mem_inst[wptr] <= rom_data_i;
          wptr           <= wptr + PW'(1);
        end
        if (pop) begin
          rptr <= rptr + PW'(1);
        end
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

`ifdef IF_FETCH_BUF_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt;

  // Every post-reset cycle without a valid head counts, including the
  // release cycle in which started is being set: three at startup, two
  // after each redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (!id_valid_o && (bubble_cnt != 32'hFFFF_FFFF)) begin
      bubble_cnt <= bubble_cnt + 32'd1;
    end
  end

  assign bubble_cnt_o = bubble_cnt;
`else
  assign bubble_cnt_o = '0;
`endif

endmodule

// File: tb/tb_if_fetch_buf.sv
module tb_if_fetch_buf;

  logic        clk;
  logic        rst;
  logic [31:0] rom_addr_o;
  logic        rom_ce_o;
  logic [31:0] rom_data_i;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic [2:0]  count_o;
  logic [31:0] bubble_cnt_o;

  int checks = 0;
  int errors = 0;

  if_fetch_buf #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .rst(rst),
    .rom_addr_o(rom_addr_o), .rom_ce_o(rom_ce_o), .rom_data_i(rom_data_i),
    .stall_i(stall_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .id_valid_o(id_valid_o), .id_pc_o(id_pc_o), .id_inst_o(id_inst_o),
    .count_o(count_o), .bubble_cnt_o(bubble_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Synchronous ROM: data appears the cycle after the request.
  always @(posedge clk) begin
    if (rom_ce_o) rom_data_i <= inst_of(rom_addr_o);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        e_ce;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [2:0]  e_count;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rpc,
                              input logic ce, input logic [31:0] addr,
                              input logic v, input logic [31:0] pc, input logic [2:0] cnt);
    vec_t t;
    t.stall = s; t.redir = r; t.rpc = rpc; t.e_ce = ce; t.e_addr = addr;
    t.e_valid = v; t.e_pc = pc; t.e_count = cnt;
    return t;
  endfunction

  vec_t tbl[32];

  initial begin
    // Startup, steady stream
    tbl[0]  = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h000, 1'b0, 32'h000, 3'd0);
    tbl[1]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h000, 1'b0, 32'h000, 3'd0);
    tbl[2]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h004, 1'b0, 32'h000, 3'd0);
    tbl[3]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h008, 1'b1, 32'h000, 3'd1);
    tbl[4]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h00C, 1'b1, 32'h004, 3'd1);
    tbl[5]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h010, 1'b1, 32'h008, 3'd1);
    // Stall for 10 cycles: FIFO fills to 4, ROM throttled, head held
    tbl[6]  = mk(1'b1, 1'b0, 32'h0,   1'b1, 32'h014, 1'b1, 32'h00C, 3'd1);
    tbl[7]  = mk(1'b1, 1'b0, 32'h0,   1'b1, 32'h018, 1'b1, 32'h00C, 3'd2);
    tbl[8]  = mk(1'b1, 1'b0, 32'h0,   1'b0, 32'h01C, 1'b1, 32'h00C, 3'd3);
    for (int i = 9; i <= 15; i++)
      tbl[i] = mk(1'b1, 1'b0, 32'h0,  1'b0, 32'h01C, 1'b1, 32'h00C, 3'd4);
    // Release: one pop per cycle, no gap, no duplicate
    tbl[16] = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h01C, 1'b1, 32'h00C, 3'd4);
    tbl[17] = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h020, 1'b1, 32'h010, 3'd3);
    tbl[18] = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h024, 1'b1, 32'h014, 3'd3);
    tbl[19] = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h028, 1'b1, 32'h018, 3'd3);
    // Redirect with count 3 and 0x28 in flight
    tbl[20] = mk(1'b0, 1'b1, 32'h100, 1'b0, 32'h02C, 1'b1, 32'h01C, 3'd3);
    tbl[21] = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h000, 3'd0);
    tbl[22] = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 32'h000, 3'd0);
    tbl[23] = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h108, 1'b1, 32'h100, 3'd1);
    tbl[24] = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h10C, 1'b1, 32'h104, 3'd1);
    // Back-to-back redirects: only 0x300 survives
    tbl[25] = mk(1'b0, 1'b1, 32'h200, 1'b0, 32'h110, 1'b1, 32'h108, 3'd1);
    tbl[26] = mk(1'b0, 1'b1, 32'h300, 1'b0, 32'h200, 1'b0, 32'h000, 3'd0);
    tbl[27] = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h300, 1'b0, 32'h000, 3'd0);
    tbl[28] = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h304, 1'b0, 32'h000, 3'd0);
    tbl[29] = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h308, 1'b1, 32'h300, 3'd1);
    tbl[30] = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h30C, 1'b1, 32'h304, 3'd1);
    tbl[31] = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h310, 1'b1, 32'h308, 3'd1);

    rst = 1'b1;
    stall_i = 1'b0;
    redirect_i = 1'b0;
    redirect_pc_i = '0;
    #1;
    chk("reset_ce", {31'd0, rom_ce_o}, 32'd0);
    chk("reset_addr", rom_addr_o, 32'h0);
    chk("reset_valid", {31'd0, id_valid_o}, 32'd0);
    chk("reset_count", {29'd0, count_o}, 32'd0);
    chk("reset_bubble", bubble_cnt_o, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 32; i++) begin
      stall_i       = tbl[i].stall;
      redirect_i    = tbl[i].redir;
      redirect_pc_i = tbl[i].rpc;
      #1;
      chk($sformatf("v%0d_ce", i),    {31'd0, rom_ce_o},   {31'd0, tbl[i].e_ce});
      chk($sformatf("v%0d_addr", i),  rom_addr_o,          tbl[i].e_addr);
      chk($sformatf("v%0d_valid", i), {31'd0, id_valid_o}, {31'd0, tbl[i].e_valid});
      chk($sformatf("v%0d_count", i), {29'd0, count_o},    {29'd0, tbl[i].e_count});
      if (tbl[i].e_valid) begin
        chk($sformatf("v%0d_pc", i),   id_pc_o,   tbl[i].e_pc);
        chk($sformatf("v%0d_inst", i), id_inst_o, inst_of(tbl[i].e_pc));
      end
      @(negedge clk);
    end

    // Build count 2 under stall, then assert reset between clock edges.
    stall_i = 1'b1;
    redirect_i = 1'b0;
    #1;
    chk("pre_rst_ce", {31'd0, rom_ce_o}, 32'd1);
    @(negedge clk);
    #1;
    chk("pre_rst_count", {29'd0, count_o}, 32'd2);
    rst = 1'b1;
    #1;
    chk("async_rst_ce", {31'd0, rom_ce_o}, 32'd0);
    chk("async_rst_addr", rom_addr_o, 32'h0);
    chk("async_rst_valid", {31'd0, id_valid_o}, 32'd0);
    chk("async_rst_pc", id_pc_o, 32'h0);
    chk("async_rst_inst", id_inst_o, 32'h0);
    chk("async_rst_count", {29'd0, count_o}, 32'd0);
    chk("async_rst_bubble", bubble_cnt_o, 32'd0);
    stall_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Restart at RESET_PC: first valid exactly 3 edges after release.
    begin
      int n;
      n = 0;
      #1;
      while (!id_valid_o && n < 10) begin
        @(negedge clk);
        #1;
        n++;
      end
      chk("restart_latency", n, 3);
      chk("restart_pc", id_pc_o, 32'h0);
      chk("restart_inst", id_inst_o, inst_of(32'h0));
    end
    // Five clean cycles total after startup (c3..c7), redirect at c8.
    repeat (5) @(negedge clk);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h40;
    #1;
    chk("bub_redir_ce", {31'd0, rom_ce_o}, 32'd0);
    @(negedge clk);
    redirect_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("bub_redir_valid", {31'd0, id_valid_o}, 32'd1);
    chk("bub_redir_pc", id_pc_o, 32'h40);
`ifdef IF_FETCH_BUF_BUBBLE_CNT_EN
    chk("bubble_cnt", bubble_cnt_o, 32'd5);
`else
    chk("bubble_cnt", bubble_cnt_o, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
